// File: rtl/mem_stage_hs.sv
// mem_stage_hs: RV32I memory stage with a variable-latency data-bus handshake,
// followed by the MEM/WB pipeline register.
// A load or store runs as IDLE (detect, stall) -> BUSY (request held until
// ready, error or timeout). Misaligned accesses never reach the bus and retire
// as precise exceptions. Everything else passes straight through in one cycle.
module mem_stage_hs #(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT     = 16,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_m,
    input  logic              w_enM,
    input  logic              wd_enM,
    input  logic              rd_enM,
    input  logic [2:0]        op_selM,
    input  logic [1:0]        WBSelM,
    input  logic [4:0]        RDM,
    input  logic [31:0]       ALU_OpM,
    input  logic [31:0]       OP2M,
    input  logic [31:0]       PCM_4,
    input  logic [31:0]       Instruction_Mem,
    input  logic              flush,
    output logic              stall_o,
    output logic              dbus_req,
    output logic              dbus_we,
    output logic [ADDR_W-3:0] dbus_addr,
    output logic [3:0]        dbus_be,
    output logic [31:0]       dbus_wdata,
    input  logic              dbus_ready,
    input  logic [31:0]       dbus_rdata,
    input  logic              dbus_err,
    output logic              valid_w,
    output logic              w_enW,
    output logic [1:0]        WBSelW,
    output logic [4:0]        RDW,
    output logic [31:0]       ALU_OpW,
    output logic [31:0]       PCW_4,
    output logic [31:0]       memop,
    output logic [31:0]       Instruction_WB,
    output logic              exc_w,
    output logic [1:0]        cause_w
);

    localparam int              CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    localparam logic [1:0] CAUSE_LD_MIS = 2'b01;
    localparam logic [1:0] CAUSE_ST_MIS = 2'b10;
    localparam logic [1:0] CAUSE_BUS    = 2'b11;

    // Byte enables for an access; unknown widths fall back to a full word.
    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'b000:  return 4'b0001 << a;
            3'b001:  return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Store data replicated across lanes so the slave can pick any lane.
    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  return {4{d[7:0]}};
            3'b001:  return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // Select the addressed lane of the read word and sign/zero extend it.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] a,
                                                input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        b = rdata[{a, 3'b000} +: 8];
        h = a[1] ? rdata[31:16] : rdata[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return rdata;
        endcase
    endfunction

    // Halfword must be 2-byte aligned, word must be 4-byte aligned.
    function automatic logic misaligned(input logic [1:0] f3lo, input logic [1:0] a);
        if (!ALIGN_CHECK) return 1'b0;
        return ((f3lo == 2'b01) && a[0]) || ((f3lo == 2'b10) && (a != 2'b00));
    endfunction

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             flush_pend;

    logic busy;
    logic mem_op;
    logic misal;
    logic start;
    logic timeout_hit;
    logic done_ok;
    logic done_err;
    logic done;

    assign busy        = (state == BUSY);
    assign mem_op      = valid_m & (rd_enM | wd_enM);
    assign misal       = mem_op & misaligned(op_selM[1:0], ALU_OpM[1:0]);
    assign start       = !busy & mem_op & !misal & !flush;
    assign timeout_hit = busy & (cnt == CNT_LAST);
    // An error beats ready; ready beats a timeout landing in the same cycle.
    assign done_err    = busy & (dbus_err | (timeout_hit & !dbus_ready));
    assign done_ok     = busy & dbus_ready & !dbus_err;
    assign done        = done_ok | done_err;

    // Stall upstream from detection until the cycle the access completes.
    assign stall_o = rst & (start | (busy & !done));

    // Bus outputs are live only in BUSY; upstream holds the M inputs stable.
    assign dbus_req   = busy;
    assign dbus_we    = busy & wd_enM;
    assign dbus_addr  = busy ? ALU_OpM[ADDR_W-1:2] : '0;
    assign dbus_be    = busy ? lane_be(op_selM, ALU_OpM[1:0]) : 4'b0000;
    assign dbus_wdata = busy ? lane_wdata(op_selM, OP2M) : 32'h0;

    // Handshake FSM: timeout counter and deferred flush of an in-flight access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            flush_pend <= 1'b0;
        end else if (!busy) begin
            flush_pend <= 1'b0;
            if (start) begin
                state <= BUSY;
                cnt   <= '0;
            end
        end else if (done) begin
            state      <= IDLE;
            flush_pend <= 1'b0;
        end else begin
            cnt <= cnt + CNT_W'(1);
            if (flush) flush_pend <= 1'b1;
        end
    end

    // ---- stage p0: next MEM/WB contents ----
    logic        load_p0;
    logic        vld_p0;
    logic        wen_p0;
    logic        exc_p0;
    logic [1:0]  cause_p0;
    logic [31:0] memop_p0;

    // Decide whether MEM/WB takes an instruction, an exception or a bubble.
    always_comb begin
        load_p0  = 1'b0;
        vld_p0   = 1'b0;
        wen_p0   = 1'b0;
        exc_p0   = 1'b0;
        cause_p0 = 2'b00;
        memop_p0 = 32'h0;
        if (!busy) begin
            if (valid_m && !flush) begin
                if (misal) begin
                    load_p0  = 1'b1;
                    vld_p0   = 1'b1;
                    exc_p0   = 1'b1;
                    cause_p0 = rd_enM ? CAUSE_LD_MIS : CAUSE_ST_MIS;
                end else if (!mem_op) begin
                    load_p0 = 1'b1;
                    vld_p0  = 1'b1;
                    wen_p0  = w_enM;
                end
            end
        end else if (done && !(flush_pend || flush)) begin
            load_p0 = 1'b1;
            vld_p0  = 1'b1;
            if (done_err) begin
                exc_p0   = 1'b1;
                cause_p0 = CAUSE_BUS;
            end else begin
                wen_p0   = w_enM;
                memop_p0 = load_extend(op_selM, ALU_OpM[1:0], dbus_rdata);
            end
        end
    end

    // ---- stage p1: MEM/WB register ----
    // Control bits update every cycle; data fields hold across bubbles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_w        <= 1'b0;
            w_enW          <= 1'b0;
            exc_w          <= 1'b0;
            cause_w        <= 2'b00;
            WBSelW         <= 2'b00;
            RDW            <= 5'd0;
            ALU_OpW        <= 32'h0;
            PCW_4          <= 32'h0;
            memop          <= 32'h0;
            Instruction_WB <= 32'h0;
        end else begin
            valid_w <= vld_p0;
            w_enW   <= wen_p0;
            exc_w   <= exc_p0;
            cause_w <= cause_p0;
            if (load_p0) begin
                WBSelW         <= WBSelM;
                RDW            <= RDM;
                ALU_OpW        <= ALU_OpM;
                PCW_4          <= PCM_4;
                memop          <= memop_p0;
                Instruction_WB <= Instruction_Mem;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_hs.sv
// tb_mem_stage_hs: scoreboard bench for mem_stage_hs. Expected WB results are
// queued when an instruction is driven and compared when valid_w appears.
// A second instance with ALIGN_CHECK=0 covers the unchecked-alignment path.
module tb_mem_stage_hs;

    logic        clk;
    logic        rst;
    logic        valid_m, w_enM, wd_enM, rd_enM, flush;
    logic [2:0]  op_selM;
    logic [1:0]  WBSelM;
    logic [4:0]  RDM;
    logic [31:0] ALU_OpM, OP2M, PCM_4, Instruction_Mem;
    logic        dbus_ready, dbus_err;
    logic [31:0] dbus_rdata;

    logic        stall_o, dbus_req, dbus_we;
    logic [29:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        valid_w, w_enW, exc_w;
    logic [1:0]  WBSelW, cause_w;
    logic [4:0]  RDW;
    logic [31:0] ALU_OpW, PCW_4, memop, Instruction_WB;

    logic        valid_m1, ready1;
    logic        stall_o1, dbus_req1, dbus_we1;
    logic [29:0] dbus_addr1;
    logic [3:0]  dbus_be1;
    logic [31:0] dbus_wdata1;
    logic        valid_w1, w_enW1, exc_w1;
    logic [1:0]  WBSelW1, cause_w1;
    logic [4:0]  RDW1;
    logic [31:0] ALU_OpW1, PCW_41, memop1, Instruction_WB1;

    mem_stage_hs #(.ADDR_W(32), .TIMEOUT(16), .ALIGN_CHECK(1'b1)) dut (
        .clk(clk), .rst(rst), .valid_m(valid_m), .w_enM(w_enM), .wd_enM(wd_enM),
        .rd_enM(rd_enM), .op_selM(op_selM), .WBSelM(WBSelM), .RDM(RDM),
        .ALU_OpM(ALU_OpM), .OP2M(OP2M), .PCM_4(PCM_4), .Instruction_Mem(Instruction_Mem),
        .flush(flush), .stall_o(stall_o), .dbus_req(dbus_req), .dbus_we(dbus_we),
        .dbus_addr(dbus_addr), .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
        .dbus_ready(dbus_ready), .dbus_rdata(dbus_rdata), .dbus_err(dbus_err),
        .valid_w(valid_w), .w_enW(w_enW), .WBSelW(WBSelW), .RDW(RDW),
        .ALU_OpW(ALU_OpW), .PCW_4(PCW_4), .memop(memop), .Instruction_WB(Instruction_WB),
        .exc_w(exc_w), .cause_w(cause_w)
    );

    mem_stage_hs #(.ADDR_W(32), .TIMEOUT(16), .ALIGN_CHECK(1'b0)) dut_na (
        .clk(clk), .rst(rst), .valid_m(valid_m1), .w_enM(w_enM), .wd_enM(wd_enM),
        .rd_enM(rd_enM), .op_selM(op_selM), .WBSelM(WBSelM), .RDM(RDM),
        .ALU_OpM(ALU_OpM), .OP2M(OP2M), .PCM_4(PCM_4), .Instruction_Mem(Instruction_Mem),
        .flush(flush), .stall_o(stall_o1), .dbus_req(dbus_req1), .dbus_we(dbus_we1),
        .dbus_addr(dbus_addr1), .dbus_be(dbus_be1), .dbus_wdata(dbus_wdata1),
        .dbus_ready(ready1), .dbus_rdata(dbus_rdata), .dbus_err(dbus_err),
        .valid_w(valid_w1), .w_enW(w_enW1), .WBSelW(WBSelW1), .RDW(RDW1),
        .ALU_OpW(ALU_OpW1), .PCW_4(PCW_41), .memop(memop1), .Instruction_WB(Instruction_WB1),
        .exc_w(exc_w1), .cause_w(cause_w1)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] memop;
        logic        wen;
        logic        exc;
        logic [1:0]  cause;
    } wb_t;

    wb_t         exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] pc_ctr   = 32'h0;

    int          ns, nr;
    logic [3:0]  b1;
    logic        w1;
    logic [29:0] a1;
    logic [31:0] d1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] mo,
                            input logic wen, input logic exc, input logic [1:0] cause);
        wb_t e;
        e.rd = rd; e.alu = alu; e.pc = pc_ctr; e.instr = {pc_ctr[15:0], 16'h0013};
        e.memop = mo; e.wen = wen; e.exc = exc; e.cause = cause;
        exp_q.push_back(e);
    endtask

    task automatic set_idle();
        valid_m = 1'b0; w_enM = 1'b0; rd_enM = 1'b0; wd_enM = 1'b0; flush = 1'b0;
        dbus_ready = 1'b0; dbus_err = 1'b0; valid_m1 = 1'b0; ready1 = 1'b0;
    endtask

    // Drive one instruction and hold it until stall_o drops (bounded).
    // Cycle 0 is the IDLE detect cycle; rdy_at/err_at/flush_at pick bus events.
    task automatic run_op(input logic [2:0] f3, input logic ld, input logic st, input logic wen,
                          input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                          input int rdy_at, input int err_at, input int flush_at,
                          input logic [31:0] rdata,
                          output int n_stall, output int n_req, output logic [3:0] be_c1,
                          output logic we_c1, output logic [29:0] addr_c1, output logic [31:0] wd_c1);
        logic done;
        done = 1'b0; n_stall = 0; n_req = 0;
        be_c1 = 4'h0; we_c1 = 1'b0; addr_c1 = 30'h0; wd_c1 = 32'h0;
        valid_m = 1'b1; w_enM = wen; rd_enM = ld; wd_enM = st; op_selM = f3; WBSelM = 2'b01;
        RDM = rd; ALU_OpM = addr; OP2M = wdata; PCM_4 = pc_ctr;
        Instruction_Mem = {pc_ctr[15:0], 16'h0013}; dbus_rdata = rdata;
        for (int c = 0; c < 64 && !done; c++) begin
            dbus_ready = (c == rdy_at);
            dbus_err   = (c == err_at);
            flush      = (c == flush_at);
            @(negedge clk);
            if (stall_o)  n_stall++;
            if (dbus_req) n_req++;
            if (c == 1) begin
                be_c1 = dbus_be; we_c1 = dbus_we; addr_c1 = dbus_addr; wd_c1 = dbus_wdata;
            end
            done = !stall_o;
            @(posedge clk); #1;
        end
        chk("op_done", {31'h0, done}, 32'h1);
        set_idle();
    endtask

    // Scoreboard: every valid WB output must match the oldest queued result.
    always @(negedge clk) begin
        wb_t e;
        if (valid_w) begin
            if (exp_q.size() == 0) begin
                chk("wb_unexpected", 32'h1, 32'h0);
            end else begin
                e = exp_q.pop_front();
                chk("wb_rd",    {27'h0, RDW}, {27'h0, e.rd});
                chk("wb_alu",   ALU_OpW, e.alu);
                chk("wb_pc",    PCW_4, e.pc);
                chk("wb_instr", Instruction_WB, e.instr);
                chk("wb_memop", memop, e.memop);
                chk("wb_wen",   {31'h0, w_enW}, {31'h0, e.wen});
                chk("wb_exc",   {31'h0, exc_w}, {31'h0, e.exc});
                chk("wb_cause", {30'h0, cause_w}, {30'h0, e.cause});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        set_idle();
        op_selM = 3'b000; WBSelM = 2'b00; RDM = 5'd0; ALU_OpM = 32'h0; OP2M = 32'h0;
        PCM_4 = 32'h0; Instruction_Mem = 32'h0; dbus_rdata = 32'h0;
        #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_stall", {31'h0, stall_o}, 32'h0);
        chk("rst_req",   {31'h0, dbus_req}, 32'h0);
        chk("rst_valid", {31'h0, valid_w}, 32'h0);
        chk("rst_exc",   {31'h0, exc_w}, 32'h0);
        chk("rst_memop", memop, 32'h0);
        chk("rst_alu",   ALU_OpW, 32'h0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // ALU pass-through
        pc_ctr += 4; push_exp(5'd5, 32'h1234, 32'h0, 1'b1, 1'b0, 2'b00);
        run_op(3'b000, 0, 0, 1, 32'h1234, 32'h0, 5'd5, -1, -1, -1, 32'h0, ns, nr, b1, w1, a1, d1);
        chk("alu_stall", ns, 0);
        chk("alu_req", nr, 0);

        // LB at 0x103, ready on the 4th BUSY cycle
        pc_ctr += 4; push_exp(5'd7, 32'h103, 32'hFFFF_FF80, 1'b1, 1'b0, 2'b00);
        run_op(3'b000, 1, 0, 1, 32'h103, 32'h0, 5'd7, 4, -1, -1, 32'h80FF_FF00, ns, nr, b1, w1, a1, d1);
        chk("lb_stall", ns, 4);
        chk("lb_req", nr, 4);
        chk("lb_be", {28'h0, b1}, 32'h8);
        chk("lb_we", {31'h0, w1}, 32'h0);

        pc_ctr += 4; push_exp(5'd8, 32'h103, 32'h0000_0080, 1'b1, 1'b0, 2'b00);
        run_op(3'b100, 1, 0, 1, 32'h103, 32'h0, 5'd8, 1, -1, -1, 32'h80FF_FF00, ns, nr, b1, w1, a1, d1);
        chk("lbu_req", nr, 1);

        pc_ctr += 4; push_exp(5'd9, 32'h102, 32'hFFFF_80FF, 1'b1, 1'b0, 2'b00);
        run_op(3'b001, 1, 0, 1, 32'h102, 32'h0, 5'd9, 1, -1, -1, 32'h80FF_FF00, ns, nr, b1, w1, a1, d1);
        chk("lh_be", {28'h0, b1}, 32'hC);

        pc_ctr += 4; push_exp(5'd10, 32'h100, 32'h0000_FF00, 1'b1, 1'b0, 2'b00);
        run_op(3'b101, 1, 0, 1, 32'h100, 32'h0, 5'd10, 2, -1, -1, 32'h80FF_FF00, ns, nr, b1, w1, a1, d1);
        chk("lhu_req", nr, 2);

        // Stores: SH, SB, SW lane generation
        pc_ctr += 4; push_exp(5'd0, 32'h202, 32'h0, 1'b0, 1'b0, 2'b00);
        run_op(3'b001, 0, 1, 0, 32'h202, 32'hAAAA_BEEF, 5'd0, 1, -1, -1, 32'h0, ns, nr, b1, w1, a1, d1);
        chk("sh_we", {31'h0, w1}, 32'h1);
        chk("sh_addr", {2'b00, a1}, 32'h80);
        chk("sh_be", {28'h0, b1}, 32'hC);
        chk("sh_wdata", d1, 32'hBEEF_BEEF);

        pc_ctr += 4; push_exp(5'd0, 32'h201, 32'h0, 1'b0, 1'b0, 2'b00);
        run_op(3'b000, 0, 1, 0, 32'h201, 32'h1234_565A, 5'd0, 1, -1, -1, 32'h0, ns, nr, b1, w1, a1, d1);
        chk("sb_be", {28'h0, b1}, 32'h2);
        chk("sb_wdata", d1, 32'h5A5A_5A5A);

        pc_ctr += 4; push_exp(5'd0, 32'h200, 32'h0, 1'b0, 1'b0, 2'b00);
        run_op(3'b010, 0, 1, 0, 32'h200, 32'hDEAD_BEEF, 5'd0, 1, -1, -1, 32'h0, ns, nr, b1, w1, a1, d1);
        chk("sw_be", {28'h0, b1}, 32'hF);
        chk("sw_wdata", d1, 32'hDEAD_BEEF);

        // Misaligned load and store
        pc_ctr += 4; push_exp(5'd11, 32'h101, 32'h0, 1'b0, 1'b1, 2'b01);
        run_op(3'b010, 1, 0, 1, 32'h101, 32'h0, 5'd11, -1, -1, -1, 32'h0, ns, nr, b1, w1, a1, d1);
        chk("lwmis_req", nr, 0);
        chk("lwmis_stall", ns, 0);

        pc_ctr += 4; push_exp(5'd0, 32'h203, 32'h0, 1'b0, 1'b1, 2'b10);
        run_op(3'b001, 0, 1, 0, 32'h203, 32'h0, 5'd0, -1, -1, -1, 32'h0, ns, nr, b1, w1, a1, d1);
        chk("shmis_req", nr, 0);

        // Timeout without ready
        pc_ctr += 4; push_exp(5'd12, 32'h100, 32'h0, 1'b0, 1'b1, 2'b11);
        run_op(3'b010, 1, 0, 1, 32'h100, 32'h0, 5'd12, -1, -1, -1, 32'h0, ns, nr, b1, w1, a1, d1);
        chk("to_req", nr, 16);
        chk("to_stall", ns, 16);
        @(negedge clk);
        chk("to_idle_req", {31'h0, dbus_req}, 32'h0);
        @(posedge clk); #1;

        // Bus error on 2nd BUSY cycle; ready+err together; ready on timeout cycle
        pc_ctr += 4; push_exp(5'd13, 32'h104, 32'h0, 1'b0, 1'b1, 2'b11);
        run_op(3'b010, 1, 0, 1, 32'h104, 32'h0, 5'd13, -1, 2, -1, 32'h0, ns, nr, b1, w1, a1, d1);
        chk("err_req", nr, 2);
        chk("err_stall", ns, 2);

        pc_ctr += 4; push_exp(5'd14, 32'h108, 32'h0, 1'b0, 1'b1, 2'b11);
        run_op(3'b010, 1, 0, 1, 32'h108, 32'h0, 5'd14, 1, 1, -1, 32'h1111_2222, ns, nr, b1, w1, a1, d1);
        chk("rdyerr_req", nr, 1);

        pc_ctr += 4; push_exp(5'd15, 32'h10C, 32'h3333_4444, 1'b1, 1'b0, 2'b00);
        run_op(3'b010, 1, 0, 1, 32'h10C, 32'h0, 5'd15, 16, -1, -1, 32'h3333_4444, ns, nr, b1, w1, a1, d1);
        chk("rdyto_req", nr, 16);

        // Flush during BUSY: access completes, result is a bubble
        pc_ctr += 4;
        run_op(3'b010, 1, 0, 1, 32'h110, 32'h0, 5'd16, 3, -1, 1, 32'h5555_6666, ns, nr, b1, w1, a1, d1);
        chk("flb_req", nr, 3);
        chk("flb_stall", ns, 3);
        @(negedge clk);
        chk("flb_valid", {31'h0, valid_w}, 32'h0);
        chk("flb_wen", {31'h0, w_enW}, 32'h0);
        chk("flb_exc", {31'h0, exc_w}, 32'h0);
        @(posedge clk); #1;

        // Flush in IDLE: no request at all
        pc_ctr += 4;
        run_op(3'b010, 1, 0, 1, 32'h114, 32'h0, 5'd17, -1, -1, 0, 32'h0, ns, nr, b1, w1, a1, d1);
        chk("fli_req", nr, 0);
        chk("fli_stall", ns, 0);

        // Normal load afterwards proves the flush state cleared
        pc_ctr += 4; push_exp(5'd18, 32'h118, 32'h7777_8888, 1'b1, 1'b0, 2'b00);
        run_op(3'b010, 1, 0, 1, 32'h118, 32'h0, 5'd18, 1, -1, -1, 32'h7777_8888, ns, nr, b1, w1, a1, d1);
        chk("post_fl_req", nr, 1);

        // ALIGN_CHECK=0 instance: misaligned LW is a normal full-word access
        pc_ctr += 4;
        valid_m1 = 1'b1; w_enM = 1'b1; rd_enM = 1'b1; wd_enM = 1'b0; op_selM = 3'b010;
        ALU_OpM = 32'h101; RDM = 5'd19; PCM_4 = pc_ctr; dbus_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("na_stall0", {31'h0, stall_o1}, 32'h1);
        chk("na_req0", {31'h0, dbus_req1}, 32'h0);
        @(posedge clk); #1;
        ready1 = 1'b1;
        @(negedge clk);
        chk("na_req1", {31'h0, dbus_req1}, 32'h1);
        chk("na_be", {28'h0, dbus_be1}, 32'hF);
        chk("na_stall1", {31'h0, stall_o1}, 32'h0);
        @(posedge clk); #1;
        set_idle();
        @(negedge clk);
        chk("na_valid", {31'h0, valid_w1}, 32'h1);
        chk("na_memop", memop1, 32'hCAFE_F00D);
        chk("na_exc", {31'h0, exc_w1}, 32'h0);
        @(posedge clk); #1;

        // Reset in the middle of BUSY abandons the access
        pc_ctr += 4;
        valid_m = 1'b1; w_enM = 1'b1; rd_enM = 1'b1; op_selM = 3'b010;
        ALU_OpM = 32'h120; RDM = 5'd20; PCM_4 = pc_ctr;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("mid_req_pre", {31'h0, dbus_req}, 32'h1);
        #2 rst = 1'b0;
        #1;
        chk("mid_req", {31'h0, dbus_req}, 32'h0);
        chk("mid_stall", {31'h0, stall_o}, 32'h0);
        chk("mid_be", {28'h0, dbus_be}, 32'h0);
        chk("mid_alu", ALU_OpW, 32'h0);
        chk("mid_memop", memop, 32'h0);
        chk("mid_rd", {27'h0, RDW}, 32'h0);
        set_idle();
        @(negedge clk) rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("post_rst_req", {31'h0, dbus_req}, 32'h0);
        chk("sb_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
- Next-generation MEM stage plus MEM/WB pipeline register for the RV32I core.
- Replaces the fixed single-cycle internal data memory with an external data-bus request/ready handshake of variable latency.
- Adds a pipeline stall output, a bus timeout, a misalignment check, load extension, store byte-lane generation, flush, and precise exception reporting to WB.

Parameters:
- ADDR_W, 32: data-bus address width. Low 2 bits are dropped on the bus.
- TIMEOUT, 16: maximum cycles in BUSY before a timeout error. Must be ≥2.
- ALIGN_CHECK, 1: 1 = misaligned accesses raise an exception; 0 = low address bits are ignored and no exception is raised.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- valid_m  in  1  instruction valid in MEM
- w_enM  in  1  regfile write enable
- wd_enM  in  1  store
- rd_enM  in  1  load
- op_selM  in  3  funct3
- WBSelM  in  2  writeback select
- RDM  in  5  destination register
- ALU_OpM  in  32  effective address / ALU result
- OP2M  in  32  store data
- PCM_4  in  32  PC+4
- Instruction_Mem  in  32  instruction word
- flush  in  1  squash MEM instruction
- stall_o  out  1  hold IF..EX/MEM
- dbus_req  out  1  bus request
- dbus_we  out  1  write
- dbus_addr  out  ADDR_W-2  word address
- dbus_be  out  4  byte enables
- dbus_wdata  out  32  lane-aligned write data
- dbus_ready  in  1  access complete
- dbus_rdata  in  32  read data, valid with ready
- dbus_err  in  1  bus error, valid with ready or alone
- valid_w, w_enW  out  1 each  WB valid, regfile write
- WBSelW  out  2
- RDW  out  5
- ALU_OpW, PCW_4, memop, Instruction_WB  out  32 each
- exc_w  out  1  exception
- cause_w  out  2  01 load misaligned, 10 store misaligned, 11 bus error/timeout

Behaviour:
- Reset (async, rst=0): every output is 0 and the state is IDLE; dbus_req drops immediately. Reset in BUSY abandons the access.
- mem_op = valid_m & (rd_enM|wd_enM). misal (only when ALIGN_CHECK=1): funct3[1:0]=01 & addr[0], or funct3[1:0]=10 & addr[1:0]≠0.
- FSM states: IDLE, BUSY.
- IDLE with mem_op & !misal: stall_o=1; next state BUSY; counter cleared; the MEM/WB register loads a bubble.
- BUSY: dbus_req=1. Bus signals are driven combinationally from the M inputs, which upstream holds stable.
  - stall_o=1 until the completing cycle.
  - Counter increments each cycle.
- BUSY completion by dbus_ready & !dbus_err: stall_o=0; MEM/WB loads the instruction with memop = extended rdata; next state IDLE.
- BUSY completion by dbus_err, or counter == TIMEOUT-1 without ready: stall_o=0; loads exc_w=1, cause=11, w_enW=0; dbus_req drops next cycle; next state IDLE.
- Misaligned op in IDLE: no bus request, no stall. Next cycle: exc_w=1, cause 01 (load) or 10 (store), w_enW=0.
- Non-memory op: one-cycle pass-through with memop=0 and exc_w=0.
- Minimum memory-op latency is 2 cycles (IDLE detect + 1 BUSY cycle with ready).
- Store lanes:
  - SB: be = 1<<addr[1:0], data byte replicated ×4.
  - SH: be = 0011 or 1100 by addr[1], halfword replicated ×2.
  - SW: be = 1111.
  - funct3 other than 000/001/010 is treated as SW.
- Loads: dbus_be follows the same rule as stores; dbus_we=0.
  - funct3 000 LB and 001 LH sign-extend the selected lane.
  - 100 LBU and 101 LHU zero-extend.
  - 010 and any other code return the full word.
- Flush:
  - In IDLE: the MEM/WB register loads a bubble and no request is started.
  - In BUSY: sets flush_pend. The access still completes on the bus, but the result loads as a bubble with no exception. flush_pend clears on completion.
- Bubble: valid_w=0, w_enW=0, exc_w=0. Data fields hold their previous values.
- Simultaneous dbus_ready and dbus_err: error wins. Timeout and ready in the same cycle: ready wins.

Test Plan:
- ALU op, valid_m=1, ALU_OpM=0x1234, RDM=5 → next cycle valid_w=1, ALU_OpW=0x1234, RDW=5, stall_o never asserted.
- LB at addr 0x103, ready after 3 BUSY cycles with rdata=0x80FF_FF00 → stall_o high 4 cycles; dbus_be=1000; memop=0xFFFF_FF80; LBU gives 0x0000_0080.
- SH at addr 0x202, OP2M=0xAAAA_BEEF → dbus_we=1, dbus_addr=0x80, dbus_be=1100, dbus_wdata=0xBEEF_BEEF.
- LW at 0x101 → no dbus_req; next cycle exc_w=1, cause_w=01, w_enW=0. With ALIGN_CHECK=0 → a normal access with be=1111.
- Load with dbus_ready never asserted, TIMEOUT=16 → dbus_req held exactly 16 cycles, then exc_w=1, cause_w=11, state returns to IDLE. dbus_err on the 2nd BUSY cycle → same response earlier.
- flush raised on the 1st BUSY cycle of a load → bus access completes, valid_w=0, w_enW=0. Separately, rst pulled low mid-BUSY → dbus_req=0 immediately and all outputs 0.
